// File: rtl/pc_update_if.sv
// Bundles the per-instruction inputs and PC-related outputs of the PC update stage.
// The slave modport is the PC unit; the master modport drives the instruction fields.
interface pc_update_if #(
  parameter int WIDTH = 64
);
  logic [3:0]       icode;
  logic [WIDTH-1:0] valP;
  logic [WIDTH-1:0] valC;
  logic [WIDTH-1:0] valM;
  logic             cond_flag;
  logic [WIDTH-1:0] NextPC;
  logic [WIDTH-1:0] PC;
  logic             halted;
  logic             instr_invalid;

  modport master (
    output icode, valP, valC, valM, cond_flag,
    input  NextPC, PC, halted, instr_invalid
  );

  modport slave (
    input  icode, valP, valC, valM, cond_flag,
    output NextPC, PC, halted, instr_invalid
  );
endinterface

// File: rtl/pc_update_unit.sv
// Y86-style PC update: selects the next PC from the instruction class and holds a
// registered PC plus a sticky halt flag that freezes the PC until reset.
module pc_update_unit #(
  parameter int               WIDTH    = 64,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  pc_update_if.slave   bus
);

  localparam logic [3:0] IC_HALT = 4'd0;
  localparam logic [3:0] IC_JXX  = 4'd7;
  localparam logic [3:0] IC_CALL = 4'd8;
  localparam logic [3:0] IC_RET  = 4'd9;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             halted_q, halted_d;
  logic [WIDTH-1:0] next_pc;
  logic             invalid;

  // Next-PC selection; halt, unsupported icodes and the halted state all hold PC.
  always_comb begin
    next_pc = pc_q;
    invalid = 1'b0;
    case (bus.icode)
      IC_HALT:                        next_pc = pc_q;
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
      4'd6, 4'd10, 4'd11:             next_pc = bus.valP;
      IC_JXX:                         next_pc = bus.cond_flag ? bus.valC : bus.valP;
      IC_CALL:                        next_pc = bus.valC;
      IC_RET:                         next_pc = bus.valM;
      default: begin
        next_pc = pc_q;
        invalid = 1'b1;
      end
    endcase
    if (halted_q) next_pc = pc_q;
  end

  always_comb begin
    pc_d     = next_pc;
    halted_d = halted_q | (bus.icode == IC_HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  assign bus.NextPC        = next_pc;
  assign bus.PC            = pc_q;
  assign bus.halted        = halted_q;
  assign bus.instr_invalid = invalid;

endmodule

// File: tb/tb_pc_update_unit.sv
// Bench for pc_update_unit: directed literal cases followed by random instruction
// streams, every cycle compared against an instruction-level model of the PC.
module tb_pc_update_unit;
  localparam int W = 64;

  logic clk;
  logic rst;
  pc_update_if #(.WIDTH(W)) bus ();

  pc_update_unit #(.WIDTH(W), .RESET_PC(64'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] m_pc;
  logic         m_halted;
  logic         m_valid = 1'b0;

  task automatic check(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, actual, actual, expected, expected, $time);
    end
  endtask

  // Architectural next-PC rule for one instruction.
  function automatic logic [W-1:0] model_next(input logic [3:0] ic, input logic cf,
                                              input logic [W-1:0] vp, input logic [W-1:0] vc,
                                              input logic [W-1:0] vm, input logic [W-1:0] pc,
                                              input logic hl);
    if (hl)                       return pc;
    if (ic == 4'd7)               return cf ? vc : vp;
    if (ic == 4'd8)               return vc;
    if (ic == 4'd9)               return vm;
    if (ic inside {[4'd1:4'd6], 4'd10, 4'd11}) return vp;
    return pc;
  endfunction

  // model state advances on the same edge as the DUT
  always @(posedge clk) begin
    if (rst) begin
      m_pc     = 64'd0;
      m_halted = 1'b0;
    end else if (m_valid) begin
      m_pc     = model_next(bus.icode, bus.cond_flag, bus.valP, bus.valC, bus.valM, m_pc, m_halted);
      m_halted = m_halted | (bus.icode == 4'd0);
    end
    if (rst) m_valid = 1'b1;
  end

  // compare process
  always @(negedge clk) begin
    if (m_valid) begin
      check("cmp_nextpc", bus.NextPC,
            model_next(bus.icode, bus.cond_flag, bus.valP, bus.valC, bus.valM, m_pc, m_halted));
      check("cmp_pc", bus.PC, m_pc);
      check("cmp_halted", {63'd0, bus.halted}, {63'd0, m_halted});
      check("cmp_invalid", {63'd0, bus.instr_invalid}, {63'd0, (bus.icode >= 4'd12)});
    end
  end

  // driver: changes inputs 1ns after a rising edge, then settles 1ns
  task automatic apply(input logic r, input logic [3:0] ic, input logic cf,
                       input logic [W-1:0] vp, input logic [W-1:0] vc, input logic [W-1:0] vm);
    @(posedge clk);
    #1;
    rst           = r;
    bus.icode     = ic;
    bus.cond_flag = cf;
    bus.valP      = vp;
    bus.valC      = vc;
    bus.valM      = vm;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.icode = 4'd1; bus.cond_flag = 1'b0;
    bus.valP = '0; bus.valC = '0; bus.valM = '0;

    // first edge is a reset edge
    apply(1'b0, 4'd7, 1'b0, 64'd243, 64'd423, 64'd0);
    check("reset_pc", bus.PC, 64'd0);
    check("reset_halted", {63'd0, bus.halted}, 64'd0);
    check("jxx_not_taken", bus.NextPC, 64'd243);
    apply(1'b0, 4'd7, 1'b1, 64'd243, 64'd423, 64'd0);
    check("jxx_taken", bus.NextPC, 64'd423);
    apply(1'b0, 4'd8, 1'b0, 64'd243, 64'd325, 64'd555);
    check("jxx_pc_after", bus.PC, 64'd423);
    check("call", bus.NextPC, 64'd325);
    apply(1'b0, 4'd9, 1'b0, 64'd243, 64'd325, 64'd555);
    check("ret", bus.NextPC, 64'd555);
    apply(1'b0, 4'd2, 1'b0, 64'd200, 64'd0, 64'd300);
    check("cmov_cf0", bus.NextPC, 64'd200);
    apply(1'b0, 4'd2, 1'b1, 64'd200, 64'd0, 64'd300);
    check("cmov_cf1", bus.NextPC, 64'd200);
    apply(1'b0, 4'd10, 1'b0, 64'd10, 64'd0, 64'd0);
    check("push", bus.NextPC, 64'd10);
    apply(1'b0, 4'd11, 1'b0, 64'd6, 64'd0, 64'd0);
    check("pop", bus.NextPC, 64'd6);
    apply(1'b0, 4'd7, 1'b1, 64'd1, 64'd100, 64'd0);
    apply(1'b0, 4'hF, 1'b0, 64'd50, 64'd0, 64'd0);
    check("inv_pc_before", bus.PC, 64'd100);
    check("inv_flag", {63'd0, bus.instr_invalid}, 64'd1);
    check("inv_nextpc", bus.NextPC, 64'd100);
    apply(1'b1, 4'd1, 1'b0, 64'd77, 64'd0, 64'd0);
    check("inv_pc_after", bus.PC, 64'd100);
    check("nextpc_in_reset", bus.NextPC, 64'd77);
    apply(1'b0, 4'd0, 1'b0, 64'd0, 64'd0, 64'd0);
    check("rst_pc", bus.PC, 64'd0);
    check("rst_halted", {63'd0, bus.halted}, 64'd0);
    apply(1'b0, 4'd7, 1'b1, 64'd5, 64'd909, 64'd0);
    check("halt_set", {63'd0, bus.halted}, 64'd1);
    check("halt_hold_next", bus.NextPC, 64'd0);
    apply(1'b0, 4'd1, 1'b0, 64'd7, 64'd0, 64'd0);
    check("halt_pc_unchanged", bus.PC, 64'd0);

    // random instruction stream with occasional resets; halts are kept rare
    for (int i = 0; i < 600; i++) begin
      logic [3:0] ic;
      logic       r;
      r = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 19) == 0) ic = 4'd0;
      else ic = 4'($urandom_range(1, 15));
      apply(r, ic, 1'($urandom_range(0, 1)),
            {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    end
    apply(1'b0, 4'd1, 1'b0, 64'd0, 64'd0, 64'd0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
